// File: rtl/q6_pkg.sv
// ----------------------------------------------------------------------------
// q6_pkg
// Shared definitions for the q6 self-test block: FSM state type, the default
// {E,W} stimulus sequence and the helper that sizes the FAIL_IDX output.
// ----------------------------------------------------------------------------
package q6_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StReport
    } q6_state_e;

    // Five {E,W} pairs, vector 0 in the MSBs.
    localparam logic [9:0] Q6_DEFAULT_VEC_SEQ = 10'b00_01_10_11_00;

    // FAIL_IDX must be able to hold NUM_VEC itself ("no mismatch").
    function automatic int unsigned q6_fail_idx_w(input int unsigned num_vec);
        return $clog2(num_vec + 1);
    endfunction

endpackage

// File: rtl/q6_hold_timer.sv
// ----------------------------------------------------------------------------
// q6_hold_timer
// Counts the clocks a stimulus vector has been held and flags the last one.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_clr    force the count back to 0
//   i_en     advance the count (wraps to 0 after the last cycle)
//   o_last   current cycle is hold cycle HOLD_CYCLES-1
// ----------------------------------------------------------------------------
module q6_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    generate
        if (HOLD_CYCLES <= 1) begin : g_single
            // Every cycle is the last hold cycle; no counter state needed.
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst_n, i_clr, i_en};
            assign o_last   = 1'b1;
        end else begin : g_count
            localparam int unsigned CW = $clog2(HOLD_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n || i_clr) begin
                    r_cnt <= '0;
                end else if (i_en) begin
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                end
            end

            assign o_last = (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/q6_bist.sv
// ----------------------------------------------------------------------------
// q6_bist
// On-chip stimulus driver / response checker for the q6 circuit. On start it
// drives NUM_VEC {E,W} vectors, each for HOLD_CYCLES clocks, samples O on the
// last hold clock of each vector and compares it against EXP_O under
// CHECK_MASK. Reports pass/fail and the first mismatching vector index.
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset (aborts a run, no done)
//   i_start     start a run (level, accepted only when idle)
//   i_o         output O of the circuit under test
//   o_e, o_w    stimulus to the circuit under test
//   o_busy      run in progress
//   o_done      one-cycle pulse at end of run
//   o_pass      result of last run, valid from done until next start
//   o_capture   sampled O values, bit i = vector i
//   o_fail_idx  first mismatching vector, NUM_VEC when none
// ----------------------------------------------------------------------------
module q6_bist
    import q6_pkg::*;
#(
    parameter int unsigned          NUM_VEC     = 5,
    parameter int unsigned          HOLD_CYCLES = 2,
    parameter logic [2*NUM_VEC-1:0] VEC_SEQ     = Q6_DEFAULT_VEC_SEQ,
    parameter logic [NUM_VEC-1:0]   EXP_O       = '0,
    parameter logic [NUM_VEC-1:0]   CHECK_MASK  = '1,
    localparam int unsigned         IDX_W       = q6_fail_idx_w(NUM_VEC)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_o,
    output logic               o_e,
    output logic               o_w,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [NUM_VEC-1:0] o_capture,
    output logic [IDX_W-1:0]   o_fail_idx
);

    localparam logic [IDX_W-1:0] NO_FAIL  = IDX_W'(NUM_VEC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    q6_state_e          r_state;
    q6_state_e          w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_VEC-1:0] r_capture;
    logic               r_pass;
    logic [IDX_W-1:0]   r_fail_idx;

    logic               w_last;
    logic               w_sample;
    logic               w_last_vec;
    logic               w_exp_bit;
    logic               w_mask_bit;
    logic [1:0]         w_pair;
    logic               w_mismatch;
    logic [IDX_W-1:0]   w_fail_idx_next;
    logic [NUM_VEC-1:0] w_capture_next;

    q6_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (r_state != StApply),
        .i_en    (r_state == StApply),
        .o_last  (w_last)
    );

    // Per-vector lookups selected by the current vector index.
    always_comb begin
        w_exp_bit      = 1'b0;
        w_mask_bit     = 1'b0;
        w_pair         = 2'b00;
        w_capture_next = r_capture;
        for (int k = 0; k < NUM_VEC; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_exp_bit         = EXP_O[k];
                w_mask_bit        = CHECK_MASK[k];
                w_pair            = VEC_SEQ[2*(NUM_VEC-1-k) +: 2];
                w_capture_next[k] = i_o;
            end
        end
    end

    assign w_sample   = (r_state == StApply) && w_last;
    assign w_last_vec = w_sample && (r_idx == LAST_IDX);
    assign w_mismatch = (i_o ^ w_exp_bit) & w_mask_bit;

    // Only the first mismatch is recorded.
    assign w_fail_idx_next = (w_sample && w_mismatch && (r_fail_idx == NO_FAIL)) ?
                             r_idx : r_fail_idx;

    // FSM: state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_next = StApply;
            StApply:  if (w_last_vec) w_state_next = StReport;
            StReport: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // FSM: outputs, decoded from registered state only.
    always_comb begin
        o_e    = 1'b0;
        o_w    = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            StIdle: ;
            StApply: begin
                o_e    = w_pair[1];
                o_w    = w_pair[0];
                o_busy = 1'b1;
            end
            StReport: o_done = 1'b1;
            default: ;
        endcase
    end

    // Vector index, capture and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_capture  <= '0;
            r_pass     <= 1'b0;
            r_fail_idx <= NO_FAIL;
        end else if (r_state == StIdle && i_start) begin
            r_idx      <= '0;
            r_capture  <= '0;
            r_pass     <= 1'b0;
            r_fail_idx <= NO_FAIL;
        end else if (w_sample) begin
            r_capture  <= w_capture_next;
            r_fail_idx <= w_fail_idx_next;
            r_idx      <= w_last_vec ? '0 : r_idx + 1'b1;
            // Result is settled as REPORT is entered so PASS is valid with DONE.
            if (w_last_vec) begin
                r_pass <= (w_fail_idx_next == NO_FAIL);
            end
        end
    end

    assign o_pass     = r_pass;
    assign o_capture  = r_capture;
    assign o_fail_idx = r_fail_idx;

endmodule

// File: tb/tb_q6_bist.sv
// ----------------------------------------------------------------------------
// tb_q6_bist
// Three q6_bist instances share clock, reset and start:
//   dut0: HOLD_CYCLES=2, CHECK_MASK=11111
//   dut1: HOLD_CYCLES=2, CHECK_MASK=11001
//   dut2: HOLD_CYCLES=1, CHECK_MASK=11111
// O is either looped back from E, from W, or driven from a random per-vector
// value (random junk on non-sampling hold cycles).
// ----------------------------------------------------------------------------
module tb_q6_bist;

    localparam int         N   = 5;
    localparam int         ND  = 3;
    localparam logic [9:0] VEC = 10'b00_01_10_11_00;
    localparam logic [4:0] EXP = 5'b01100;

    typedef struct {
        int         k;
        logic       e;
        logic       w;
        logic       busy;
        logic       done;
        logic [4:0] cap;
        logic       pass;
        logic [2:0] fidx;
    } tl_t;

    typedef struct {
        int         k;
        logic [4:0] cap;
        logic       pass;
        logic [2:0] fidx;
        int         cyc;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    int         mode;
    logic [4:0] ov;
    logic       rand_o [ND];

    logic       o_v    [ND];
    logic       e_v    [ND];
    logic       w_v    [ND];
    logic       busy_v [ND];
    logic       done_v [ND];
    logic       pass_v [ND];
    logic [4:0] cap_v  [ND];
    logic [2:0] fidx_v [ND];

    int         n_chk;
    int         n_fail;
    int         gcyc;

    int         m_cyc  [ND];
    logic [4:0] m_cap  [ND];
    logic       m_pass [ND];
    logic [2:0] m_fidx [ND];

    tl_t        tl_q[$];
    res_t       res_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        q6_bist #(
            .NUM_VEC     (5),
            .HOLD_CYCLES ((g == 2) ? 1 : 2),
            .VEC_SEQ     (10'b00_01_10_11_00),
            .EXP_O       (5'b01100),
            .CHECK_MASK  ((g == 1) ? 5'b11001 : 5'b11111)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_start    (start),
            .i_o        (o_v[g]),
            .o_e        (e_v[g]),
            .o_w        (w_v[g]),
            .o_busy     (busy_v[g]),
            .o_done     (done_v[g]),
            .o_pass     (pass_v[g]),
            .o_capture  (cap_v[g]),
            .o_fail_idx (fidx_v[g])
        );
        assign o_v[g] = (mode == 0) ? e_v[g] : (mode == 1) ? w_v[g] : rand_o[g];
    end

    function automatic int hold_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic logic [4:0] mask_of(input int k);
        return (k == 1) ? 5'b11001 : 5'b11111;
    endfunction

    function automatic logic bit_of(input logic [4:0] v, input int i);
        return v[i];
    endfunction

    function automatic logic e_of(input int i);
        logic [9:0] s;
        s = VEC >> (2 * (N - 1 - i) + 1);
        return s[0];
    endfunction

    function automatic logic w_of(input int i);
        logic [9:0] s;
        s = VEC >> (2 * (N - 1 - i));
        return s[0];
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, k, gcyc, act, exp);
        end
    endtask

    // Reference model: counts cycles into a run and pushes, per DUT, what every
    // output must look like in the cycle that follows each rising edge.
    initial begin
        gcyc = 0;
        for (int k = 0; k < ND; k++) begin
            m_cyc[k]  = 0;
            m_cap[k]  = '0;
            m_pass[k] = 1'b0;
            m_fidx[k] = 3'(N);
            rand_o[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            gcyc++;
            if (!rst_n) res_q.delete();
            for (int k = 0; k < ND; k++) begin
                int   h;
                int   vi;
                tl_t  t;
                res_t r;
                h = hold_of(k);
                if (!rst_n) begin
                    m_cyc[k]  = 0;
                    m_cap[k]  = '0;
                    m_pass[k] = 1'b0;
                    m_fidx[k] = 3'(N);
                end else if (m_cyc[k] == 0) begin
                    if (start) begin
                        m_cyc[k]  = 1;
                        m_cap[k]  = '0;
                        m_pass[k] = 1'b0;
                        m_fidx[k] = 3'(N);
                        // Whole-run outcome straight from the vector rules.
                        r.k    = k;
                        r.cap  = ov;
                        r.fidx = 3'(N);
                        for (int i = N - 1; i >= 0; i--) begin
                            if (((bit_of(ov, i) ^ bit_of(EXP, i)) & bit_of(mask_of(k), i)) != 1'b0)
                                r.fidx = 3'(i);
                        end
                        r.pass = (r.fidx == 3'(N));
                        r.cyc  = gcyc + N * h;
                        res_q.push_back(r);
                    end
                end else if (m_cyc[k] <= N * h) begin
                    if (m_cyc[k] % h == 0) begin
                        vi = m_cyc[k] / h - 1;
                        m_cap[k][vi] = bit_of(ov, vi);
                        if ((((bit_of(ov, vi) ^ bit_of(EXP, vi)) & bit_of(mask_of(k), vi)) != 1'b0)
                            && m_fidx[k] == 3'(N))
                            m_fidx[k] = 3'(vi);
                    end
                    if (m_cyc[k] == N * h) m_pass[k] = (m_fidx[k] == 3'(N));
                    m_cyc[k]++;
                end else begin
                    m_cyc[k] = 0;
                end
                t.k    = k;
                t.busy = (m_cyc[k] >= 1 && m_cyc[k] <= N * h);
                t.e    = t.busy ? e_of((m_cyc[k] - 1) / h) : 1'b0;
                t.w    = t.busy ? w_of((m_cyc[k] - 1) / h) : 1'b0;
                t.done = (m_cyc[k] == N * h + 1);
                t.cap  = m_cap[k];
                t.pass = m_pass[k];
                t.fidx = m_fidx[k];
                tl_q.push_back(t);
            end
            #1;
            for (int k = 0; k < ND; k++) begin
                int h;
                h = hold_of(k);
                if (m_cyc[k] >= 1 && m_cyc[k] <= N * h && (m_cyc[k] - 1) % h == h - 1)
                    rand_o[k] = bit_of(ov, (m_cyc[k] - 1) / h);
                else
                    rand_o[k] = 1'($urandom_range(1, 0));
            end
        end
    end

    // Monitor: per-cycle outputs against the timeline, run results on DONE.
    initial begin
        forever begin
            @(negedge clk);
            while (tl_q.size() > 0) begin
                tl_t t;
                t = tl_q.pop_front();
                check("ctrl{e,w,busy,done}", t.k,
                      32'({e_v[t.k], w_v[t.k], busy_v[t.k], done_v[t.k]}),
                      32'({t.e, t.w, t.busy, t.done}));
                check("result{cap,pass,fidx}", t.k,
                      32'({cap_v[t.k], pass_v[t.k], fidx_v[t.k]}),
                      32'({t.cap, t.pass, t.fidx}));
            end
            for (int k = 0; k < ND; k++) begin
                if (done_v[k] === 1'b1) begin
                    int   found;
                    res_t r;
                    found = -1;
                    for (int j = 0; j < res_q.size(); j++)
                        if (found < 0 && res_q[j].k == k) found = j;
                    if (found < 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL done_unexpected dut%0d cycle %0d: got done=1, expected no run",
                                 k, gcyc);
                    end else begin
                        r = res_q[found];
                        res_q.delete(found);
                        check("done_cycle", k, 32'(gcyc), 32'(r.cyc));
                        check("done_capture", k, 32'(cap_v[k]), 32'(r.cap));
                        check("done_pass", k, 32'(pass_v[k]), 32'(r.pass));
                        check("done_fail_idx", k, 32'(fidx_v[k]), 32'(r.fidx));
                    end
                end
            end
        end
    end

    task automatic set_mode(input int m);
        mode = m;
        for (int i = 0; i < N; i++) begin
            if (m == 0)      ov[i] = e_of(i);
            else if (m == 1) ov[i] = w_of(i);
        end
        if (m == 2) ov = 5'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (m_cyc[0] == 0 && m_cyc[1] == 0 && m_cyc[2] == 0);
        end
        check("wait_idle_timeout", 0, 32'(ok), 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 0;
        ov     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback O=E, then O=W.
        set_mode(0);
        pulse_start();
        wait_idle();
        set_mode(1);
        pulse_start();
        wait_idle();

        // Random per-vector O values.
        repeat (12) begin
            set_mode(2);
            pulse_start();
            wait_idle();
        end

        // Start re-asserted while applying must not restart.
        set_mode(0);
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start held high: back-to-back runs.
        set_mode(2);
        start = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset during cycle 4 of a run, then a clean run.
        set_mode(2);
        pulse_start();
        for (int n = 0; n < 20 && m_cyc[0] != 4; n++) @(negedge clk);
        check("reset_point_reached", 0, 32'(m_cyc[0]), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_mode(0);
        pulse_start();
        wait_idle();

        repeat (3) @(negedge clk);
        check("runs_without_done", 0, 32'(res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
